fpcvt_arb: RTL and testbench
============================

FPCVT_ARB -- requirements
Module: fpcvt_arb

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the completed-conversion counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have ports req0/req1, input, 1 each, requester asks for a conversion; held high until its grant.
REQ-005 SHALL have ports d0/d1, input, 12 each, two's-complement sample; valid while the matching req is high.
REQ-006 SHALL have ports gnt0/gnt1, output, 1 each, one-cycle pulse on the cycle the sample is captured.
REQ-007 SHALL have port out_valid, output, 1, result available.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-009 SHALL have port out_id, output, 1, index of the requester that owns the result.
REQ-010 SHALL have ports S (1), E (3), F (4), outputs, the registered floating-point result.
REQ-011 SHALL have port done_cnt, output, CNT_W, count of accepted results.

Function
REQ-012 SHALL implement an FSM with states IDLE, CONV and HOLD.
REQ-013 IDLE: if any req is high, SHALL grant one, latch its d into d_reg, pulse its gnt, record its id, then go to CONV; otherwise it SHALL stay in IDLE.
REQ-014 Arbitration SHALL be round-robin: when both are requesting, the requester not granted last wins; the last-granted pointer SHALL reset to 1, so req0 wins the first tie.
REQ-015 CONV: SHALL register the fpcvt result of d_reg into S/E/F/out_id, set out_valid, then go to HOLD.
REQ-016 HOLD: out_valid and S/E/F/out_id SHALL stay stable until the cycle with out_valid and out_ready both high; that cycle SHALL increment done_cnt and go to IDLE, with out_valid low on the next cycle.
REQ-017 Latency: grant to out_valid SHALL be 2 cycles. Minimum spacing between grants SHALL be 3 cycles.
REQ-018 Conversion: S SHALL be d[11]; magnitude SHALL be |d|, with -2048 saturating to 2047.
REQ-019 Conversion: with lz = leading zeros of the 12-bit magnitude, E SHALL be 8-lz for lz<=7, else 0.
REQ-020 Conversion: F SHALL be the 4 bits starting at the leading one (for lz>=8, magnitude[3:0]).
REQ-021 Rounding: the next lower bit SHALL round F up. If F overflows 1111, F SHALL become 1000 and E SHALL increment. If E is already 7, E SHALL stay 7 and F SHALL be 1111.
REQ-022 A req dropping while not granted SHALL be ignored. A req held high through CONV/HOLD SHALL be serviced in the next IDLE.
REQ-023 done_cnt SHALL wrap modulo 2^CNT_W.
REQ-024 out_ready high while out_valid is low SHALL have no effect.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, with gnt0/gnt1/out_valid/out_id/S/E/F/done_cnt/d_reg all 0 and the last-granted pointer at 1.
REQ-026 Reset asserted mid-conversion SHALL discard the in-flight sample; after release no stale out_valid SHALL appear.

Structure
REQ-027 State encodings and the width constants (12, 3, 4) SHALL live in a shared package/header fpcvt_pkg.
REQ-028 The conversion SHALL be a combinational sub-module fpcvt (D -> S, E, F) instantiated once on d_reg; the controller SHALL contain no conversion logic.

Verification
REQ-029 The bench SHALL cover: req0, d0=0x064 (100), out_ready=1 -> gnt0 at cycle 0; out_valid at cycle 2 with S=0, E=011, F=1101, out_id=0; done_cnt=1.
REQ-030 The bench SHALL cover: req0 and req1 both held, d0=0x800, d1=0x7FF -> grants alternate 0,1,0,1. Both results SHALL be S=0/S=1 as appropriate with E=111, F=1111.
REQ-031 The bench SHALL cover: d=0x005, out_ready low for 5 cycles -> out_valid held, S=0, E=000, F=0101 stable throughout; the next grant only after acceptance.
REQ-032 The bench SHALL cover: d=0x07C (124) -> rounding overflow gives E=100, F=1000.
REQ-033 The bench SHALL cover: rst_n pulsed low during CONV -> all outputs 0 asynchronously; no out_valid after release until a new req.
REQ-034 The bench SHALL cover: 2^CNT_W+1 accepted conversions -> done_cnt=1.

Source files
------------

// File: rtl/fpcvt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpcvt_pkg
//  Purpose  : Shared widths and controller state encoding for the fixed-to-
//             float converter and its two-requester arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package fpcvt_pkg;

  localparam int D_W = 12;  // two's-complement sample width
  localparam int E_W = 3;   // exponent width
  localparam int F_W = 4;   // mantissa width (leading one kept explicitly)

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fpcvt.sv
`default_nettype none
// ============================================================================
//  Module   : fpcvt
//  Purpose  : Combinational 12-bit two's-complement to S/E3/F4 conversion
//             with round-half-up on the bit below F and saturation at E=7.
//  Revision : 1.0  initial release
// ============================================================================
module fpcvt
  import fpcvt_pkg::*;
(
  input  logic [D_W-1:0] D,
  output logic           S,
  output logic [E_W-1:0] E,
  output logic [F_W-1:0] F
);

  logic [D_W-1:0] mag;
  logic [3:0]     lz;
  logic [4:0]     norm;   // leading four bits after normalisation plus round bit
  logic [4:0]     fr;     // rounded mantissa with carry-out

  // Magnitude, leading-zero count and rounded normalised mantissa
  always_comb begin
    S    = D[D_W-1];
    mag  = D;
    lz   = 4'd12;
    norm = '0;
    fr   = '0;
    E    = '0;
    F    = '0;

    // -2048 has no positive counterpart in 12 bits, so it saturates
    if (D[D_W-1]) begin
      mag = (D == 12'h800) ? 12'h7FF : -D;
    end

    // Ascending scan: the highest set bit is the last to write lz
    for (int i = 0; i < D_W; i++) begin
      if (mag[i]) lz = 4'(11 - i);
    end

    norm = 5'((mag << lz) >> 7);

    if (lz >= 4'd8) begin
      // Subnormal-like range: no implicit leading one, no rounding bit
      E = '0;
      F = mag[F_W-1:0];
    end else begin
      fr = {1'b0, norm[4:1]} + {4'b0000, norm[0]};
      if (fr[4]) begin
        if (lz == 4'd1) begin
          E = 3'd7;
          F = 4'hF;
        end else begin
          E = 3'(4'd9 - lz);
          F = 4'h8;
        end
      end else begin
        E = 3'(4'd8 - lz);
        F = fr[F_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpcvt_arb.sv
`default_nettype none
// ============================================================================
//  Module   : fpcvt_arb
//  Purpose  : Round-robin arbiter for two requesters feeding one fpcvt
//             converter; result held with valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module fpcvt_arb
  import fpcvt_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [D_W-1:0]   d0,
  input  logic [D_W-1:0]   d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic             S,
  output logic [E_W-1:0]   E,
  output logic [F_W-1:0]   F,
  output logic [CNT_W-1:0] done_cnt
);

  state_t         state, state_nxt;
  logic           last;      // index granted most recently
  logic           win;       // index that would be granted this cycle
  logic           take;      // a sample is captured this cycle
  logic [D_W-1:0] d_reg;
  logic           id_reg;
  logic           cvt_s;
  logic [E_W-1:0] cvt_e;
  logic [F_W-1:0] cvt_f;

  fpcvt u_fpcvt (
    .D (d_reg),
    .S (cvt_s),
    .E (cvt_e),
    .F (cvt_f)
  );

  // Round-robin choice: on a tie the requester not granted last wins
  always_comb begin
    win = (req0 & req1) ? ~last : req1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req0 | req1) state_nxt = ST_CONV;
      ST_CONV: state_nxt = ST_HOLD;
      ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Grant pulses; gated by rst_n so reset silences them immediately
  always_comb begin
    take = (state == ST_IDLE) & (req0 | req1) & rst_n;
    gnt0 = take & ~win;
    gnt1 = take & win;
  end

  // Capture, result registers and completion counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= 1'b1;
      d_reg     <= '0;
      id_reg    <= 1'b0;
      out_valid <= 1'b0;
      out_id    <= 1'b0;
      S         <= 1'b0;
      E         <= '0;
      F         <= '0;
      done_cnt  <= '0;
    end else begin
      if (take) begin
        d_reg  <= win ? d1 : d0;
        id_reg <= win;
        last   <= win;
      end
      if (state == ST_CONV) begin
        S         <= cvt_s;
        E         <= cvt_e;
        F         <= cvt_f;
        out_id    <= id_reg;
        out_valid <= 1'b1;
      end
      if ((state == ST_HOLD) && out_valid && out_ready) begin
        out_valid <= 1'b0;
        done_cnt  <= done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpcvt_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpcvt_arb
//  Purpose  : Scoreboard bench for fpcvt_arb with directed scenarios and a
//             randomized phase against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fpcvt_arb;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [11:0]      d0 = '0, d1 = '0;
  logic             gnt0, gnt1, out_valid, out_id, S;
  logic             out_ready = 1'b0;
  logic [2:0]       E;
  logic [3:0]       F;
  logic [CNT_W-1:0] done_cnt;

  fpcvt_arb #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .gnt0(gnt0), .gnt1(gnt1), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .S(S), .E(E), .F(F), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int id; logic [11:0] d; int gcyc;} item_t;

  item_t q[$];
  int    gnt_log[$];
  int    res_log[$];
  int    checks = 0, errors = 0;
  int    cycle = 0, exp_cnt = 0, last = 1;
  bit    busy = 0, prev_valid = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion from value arithmetic: returns {S,E[2:0],F[3:0]}
  function automatic int model(input logic [11:0] d);
    int v, s, mag, bits, sh, e, f;
    v   = int'($signed(d));
    s   = (v < 0) ? 1 : 0;
    mag = (v < 0) ? -v : v;
    if (mag > 2047) mag = 2047;
    bits = 0;
    while ((1 << bits) <= mag) bits++;
    if (bits <= 4) begin
      e = 0;
      f = mag;
    end else begin
      sh = bits - 4;
      f  = (mag + (1 << (sh - 1))) >> sh;
      e  = sh;
      if (f == 16) begin f = 8; e = e + 1; end
      if (e > 7)   begin e = 7; f = 15;    end
    end
    return (s << 7) | (e << 4) | f;
  endfunction

  // Monitor: arbitration model, result scoreboard and counter check
  initial begin
    item_t it;
    int    win, exp_g;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        busy = 0; last = 1; exp_cnt = 0; prev_valid = 0;
      end else begin
        cycle++;
        exp_g = 0;
        if (!busy && (req0 || req1)) begin
          win   = (req0 && req1) ? (last == 1 ? 0 : 1) : (req0 ? 0 : 1);
          exp_g = win ? 2 : 1;
          it.id = win; it.d = win ? d1 : d0; it.gcyc = cycle;
          q.push_back(it);
          gnt_log.push_back(win);
          busy = 1;
          last = win;
        end
        chk("arb_gnt", int'({gnt1, gnt0}), exp_g);
        chk("done_cnt", int'(done_cnt), exp_cnt % (1 << CNT_W));
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("valid_without_request", int'(out_valid), 0);
          end else begin
            chk("result", int'({out_id, S, E, F}), (q[0].id << 8) | model(q[0].d));
            if (!prev_valid) chk("latency", cycle - q[0].gcyc, 2);
            if (out_ready) begin
              res_log.push_back(int'({out_id, S, E, F}));
              void'(q.pop_front());
              busy = 0;
              exp_cnt++;
            end
          end
        end
        prev_valid = out_valid;
      end
    end
  end

  task automatic wait_gnt(output int id);
    id = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin id = gnt1 ? 1 : 0; break; end
    end
    if (id < 0) chk("gnt_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    req0 = 0; req1 = 0;
    rst_n = 0;
    #1;
    chk("reset_outputs", int'({gnt0, gnt1, out_valid, out_id, S, E, F, done_cnt}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  function automatic logic [11:0] rand_d();
    logic [11:0] tbl [8];
    tbl = '{12'h000, 12'h800, 12'h7FF, 12'h07C, 12'h005, 12'hFFF, 12'h010, 12'h01F};
    if ($urandom_range(0, 2) == 0) return tbl[$urandom_range(0, 7)];
    return 12'($urandom);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int id;
    int ids[4];
    bit g0, g1;

    // Reset state
    #1;
    chk("reset_outputs", int'({gnt0, gnt1, out_valid, out_id, S, E, F, done_cnt}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Single conversion of 100
    out_ready = 1;
    res_log.delete();
    req0 = 1; d0 = 12'h064;
    wait_gnt(id);
    chk("t1_gnt_id", id, 0);
    req0 = 0;
    wait_idle();
    chk("t1_result", res_log[0], 9'b0_0_011_1101);
    @(negedge clk);
    chk("t1_done_cnt", int'(done_cnt), 1);

    // Tie arbitration after reset: 0,1,0,1 with saturating extremes
    pulse_reset();
    res_log.delete(); gnt_log.delete();
    req0 = 1; d0 = 12'h800; req1 = 1; d1 = 12'h7FF;
    for (int k = 0; k < 4; k++) wait_gnt(ids[k]);
    req0 = 0; req1 = 0;
    for (int k = 0; k < 4; k++) chk("t2_order", ids[k], k % 2);
    wait_idle();
    chk("t2_count", res_log.size(), 4);
    for (int k = 0; k < res_log.size(); k++)
      chk("t2_result", res_log[k], ((k % 2) << 8) | (((k % 2) == 0 ? 1 : 0) << 7) | (7 << 4) | 15);

    // Back-pressure: result held while ready is low, req1 waits
    out_ready = 0;
    req0 = 1; d0 = 12'h005;
    wait_gnt(id);
    req0 = 0; req1 = 1; d1 = rand_d();
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold", int'({out_valid, S, E, F}), 9'b1_0_000_0101);
    end
    @(posedge clk); #1 out_ready = 1;
    wait_gnt(id);
    chk("t3_next_id", id, 1);
    req1 = 0;
    wait_idle();

    // Rounding overflow bumps exponent
    res_log.delete();
    req1 = 1; d1 = 12'h07C;
    wait_gnt(id);
    req1 = 0;
    wait_idle();
    chk("t4_result", res_log[0], 9'b1_0_100_1000);

    // Reset during CONV drops the in-flight sample
    req0 = 1; d0 = rand_d();
    wait_gnt(id);
    req0 = 0;
    rst_n = 0;
    #1;
    chk("t5_async_reset", int'({gnt0, gnt1, out_valid, out_id, S, E, F, done_cnt}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_no_stale_valid", int'({out_valid, gnt0, gnt1}), 0);
    end

    // Counter wrap after 2^CNT_W + 1 acceptances
    pulse_reset();
    out_ready = 1;
    for (int n = 0; n < (1 << CNT_W) + 1; n++) begin
      req0 = 1; d0 = rand_d();
      wait_gnt(id);
      req0 = 0;
      wait_idle();
    end
    @(negedge clk);
    chk("t6_wrap", int'(done_cnt), 1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      g0 = gnt0; g1 = gnt1;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 2) != 0);
      if (g0) begin
        req0 = ($urandom_range(0, 3) == 0); d0 = rand_d();
      end else if (req0 && $urandom_range(0, 15) == 0) begin
        req0 = 0;
      end else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; d0 = rand_d();
      end
      if (g1) begin
        req1 = ($urandom_range(0, 3) == 0); d1 = rand_d();
      end else if (req1 && $urandom_range(0, 15) == 0) begin
        req1 = 0;
      end else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; d1 = rand_d();
      end
    end
    req0 = 0; req1 = 0; out_ready = 1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
